osd_dii_arbiter: RTL and testbench

Packet-atomic round-robin arbiter that merges N DII flit streams into one DII output port. Inside osd_debug_processor it shares the single debug_out path between the register-access responses and the debug coprocessor's outbound packets. Once a packet has started, its source keeps the grant until the flit carrying last is accepted. An optional skid-buffered output stage breaks the ready/valid timing path toward the debug ring.

---
 rtl/dii_package.sv | 13 +
 rtl/osd_util.sv | 11 +
 rtl/osd_dii_skid_buffer.sv | 69 ++++++
 rtl/osd_dii_arbiter.sv | 160 ++++++++++++++++
 tb/tb_osd_dii_arbiter.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dii_package.sv
// dii_package
// Shared DII flit definition used by every block that moves debug
// interconnect traffic. A flit carries one 16-bit word plus a packet
// delimiter; valid qualifies the whole flit.
package dii_package;

    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } dii_flit;

endpackage

// File: rtl/osd_util.sv
// osd_util
// Small helpers shared across OSD blocks.
//   clog2_min1(n) : bits needed to index n items, never less than 1 so that
//                   index ports stay legal for degenerate sizes.
package osd_util;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/osd_dii_skid_buffer.sv
// osd_dii_skid_buffer
// Two-entry skid buffer for a DII stream. Sustains one flit per cycle and
// takes in_ready purely from registered occupancy, so the upstream ready
// path no longer depends on the downstream out_ready.
//
// Ports:
//   clk       : clock
//   rst       : synchronous active-high reset, empties the buffer
//   in_flit   : upstream flit (push when valid && in_ready)
//   in_ready  : buffer not full
//   out_flit  : head entry, valid while the buffer is non-empty
//   out_ready : downstream ready (pop when out_flit.valid && out_ready)
module osd_dii_skid_buffer
    import dii_package::*;
(
    input  logic    clk,
    input  logic    rst,
    input  dii_flit in_flit,
    output logic    in_ready,
    output dii_flit out_flit,
    input  logic    out_ready
);

    logic [1:0] count_q;
    dii_flit    head_q;
    dii_flit    tail_q;
    logic       push;
    logic       pop;

    assign in_ready = (count_q != 2'd2);
    assign push     = in_flit.valid && in_ready;
    assign pop      = (count_q != 2'd0) && out_ready;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the values from before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: the entry registers are deliberately not reset; count_q qualifies
    // them, so stale contents are never visible after rst.
    always_ff @(posedge clk) begin
        unique case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) head_q <= in_flit;
                else                 tail_q <= in_flit;
            end
            2'b01: head_q <= tail_q;
            // Push and pop together only happen with exactly one entry held,
            // so the new flit becomes the head directly.
            2'b11: head_q <= in_flit;
            default: ;
        endcase
    end

    always_comb begin
        out_flit       = head_q;
        out_flit.valid = (count_q != 2'd0);
    end

endmodule

// File: rtl/osd_dii_arbiter.sv
// osd_dii_arbiter
// Packet-atomic round-robin arbiter merging N DII streams onto one port.
// A source that gets its first flit accepted keeps the grant until its last
// flit is accepted; between packets the search starts one past the most
// recent owner. REG_OUT=1 adds a 2-entry skid buffer on the output.
//
// Ports:
//   clk       : clock
//   rst       : synchronous active-high reset
//   in_flit   : N request streams {valid,last,data}
//   in_ready  : per-stream ready, only ever asserted toward the granted stream
//   out_flit  : merged stream
//   out_ready : downstream ready
//   grant_id  : current owner, or most recent winner when idle
//   locked    : a packet is in progress
module osd_dii_arbiter
    import dii_package::*, osd_util::*;
#(
    parameter int N       = 2,
    parameter bit REG_OUT = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  dii_flit [N-1:0]              in_flit,
    output logic    [N-1:0]              in_ready,
    output dii_flit                      out_flit,
    input  logic                         out_ready,
    output logic [clog2_min1(N)-1:0]     grant_id,
    output logic                         locked
);

    localparam int GW = clog2_min1(N);

    typedef enum logic {IDLE, LOCKED} arb_state_e;

    arb_state_e    state_q, state_d;
    logic [GW-1:0] owner_q, owner_d;
    logic [GW-1:0] rr_last_q, rr_last_d;
    logic [GW-1:0] grant_q;
    logic [GW-1:0] winner;
    logic [GW-1:0] cand;
    logic [GW-1:0] sel;
    logic          any_valid;
    dii_flit       arb_flit;
    logic          acc;
    logic          stage_base_ready;
    logic          stage_ready;

    // Stage is never ready during rst so no flit is taken while resetting.
    assign stage_ready = stage_base_ready && !rst;
    assign locked      = (state_q == LOCKED);

    // Round-robin search starting one past the previous owner.
    always_comb begin
        any_valid = 1'b0;
        winner    = rr_last_q;
        cand      = rr_last_q;
        for (int k = 1; k <= N; k++) begin
            cand = GW'((int'(rr_last_q) + k) % N);
            if (!any_valid && in_flit[cand].valid) begin
                any_valid = 1'b1;
                winner    = cand;
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        sel       = (state_q == LOCKED) ? owner_q : winner;
        arb_flit  = in_flit[sel];
        acc       = arb_flit.valid && stage_ready;
        in_ready  = '0;
        for (int i = 0; i < N; i++) begin
            if (sel == GW'(i)) in_ready[i] = stage_ready;
        end

        unique case (state_q)
            IDLE: begin
                if (acc) begin
                    if (arb_flit.last) begin
                        rr_last_d = winner;
                    end else begin
                        state_d = LOCKED;
                        owner_d = winner;
                    end
                end
            end
            LOCKED: begin
                // Owner bubbles simply stall here; nobody else is considered.
                if (acc && arb_flit.last) begin
                    state_d   = IDLE;
                    rr_last_d = owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        if (rst)                    grant_id = '0;
        else if (state_q == LOCKED) grant_id = owner_q;
        else if (any_valid)         grant_id = winner;
        else                        grant_id = grant_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            rr_last_q <= GW'(N - 1);
            grant_q   <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            grant_q   <= grant_id;
        end
    end

    generate
        if (REG_OUT) begin : g_skid
            dii_flit skid_in;
            dii_flit skid_out;
            logic    skid_ready;

            always_comb begin
                skid_in       = arb_flit;
                skid_in.valid = acc;
            end

            osd_dii_skid_buffer u_skid (
                .clk       (clk),
                .rst       (rst),
                .in_flit   (skid_in),
                .in_ready  (skid_ready),
                .out_flit  (skid_out),
                .out_ready (out_ready)
            );

            assign stage_base_ready = skid_ready;

            always_comb begin
                out_flit       = skid_out;
                out_flit.valid = skid_out.valid && !rst;
            end
        end else begin : g_pass
            assign stage_base_ready = out_ready;

            always_comb begin
                out_flit       = arb_flit;
                out_flit.valid = arb_flit.valid && !rst;
            end
        end
    endgenerate

endmodule

// File: tb/tb_osd_dii_arbiter.sv
// tb_osd_dii_arbiter
// Directed bench for osd_dii_arbiter. Three instances share clk/rst:
//   u_a : N=2, REG_OUT=0   (round robin, packet lock, owner bubbles)
//   u_b : N=2, REG_OUT=1   (skid stall/drain, reset mid-packet)
//   u_c : N=4, REG_OUT=1   (long run with random out_ready)
// Inputs change just after the falling edge; outputs are sampled 1 ns later
// and the handshake seen there is the one taken at the next rising edge.
module tb_osd_dii_arbiter;
    import dii_package::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    dii_flit [1:0] a_in,  b_in;
    logic    [1:0] a_rdy, b_rdy;
    dii_flit       a_out, b_out;
    logic          a_ordy, b_ordy;
    logic    [0:0] a_gid, b_gid;
    logic          a_lock, b_lock;

    dii_flit [3:0] c_in;
    logic    [3:0] c_rdy;
    dii_flit       c_out;
    logic          c_ordy;
    logic    [1:0] c_gid;
    logic          c_lock;

    osd_dii_arbiter #(.N(2), .REG_OUT(1'b0)) u_a (
        .clk(clk), .rst(rst), .in_flit(a_in), .in_ready(a_rdy),
        .out_flit(a_out), .out_ready(a_ordy), .grant_id(a_gid), .locked(a_lock)
    );

    osd_dii_arbiter #(.N(2), .REG_OUT(1'b1)) u_b (
        .clk(clk), .rst(rst), .in_flit(b_in), .in_ready(b_rdy),
        .out_flit(b_out), .out_ready(b_ordy), .grant_id(b_gid), .locked(b_lock)
    );

    osd_dii_arbiter #(.N(4), .REG_OUT(1'b1)) u_c (
        .clk(clk), .rst(rst), .in_flit(c_in), .in_ready(c_rdy),
        .out_flit(c_out), .out_ready(c_ordy), .grant_id(c_gid), .locked(c_lock)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Flit sources for u_a (0) and u_b (1): queues of {last,data}.
    logic [16:0] srcq [2][2][16];
    int          wp   [2][2];
    int          rp   [2][2];
    bit          en   [2][2];

    // Sources for u_c: each stream sends 2-flit packets tagged {stream,phase,seq}.
    bit          c_run;
    logic        c_phase [4];
    logic [12:0] c_seq   [4];
    int          c_cnt   [4];
    int          exp_k;
    logic        exp_ph;

    // Samples taken mid-cycle.
    dii_flit     sa_out, sb_out;
    logic [1:0]  sa_rdy, sb_rdy, sa_vld, sb_vld;
    logic        sa_lock, sb_lock;
    logic [0:0]  sa_gid, sb_gid;

    task automatic clear_src(input int inst);
        for (int s = 0; s < 2; s++) begin
            wp[inst][s] = 0;
            rp[inst][s] = 0;
            en[inst][s] = 1'b1;
        end
    endtask

    task automatic push_flit(input int inst, input int s, input logic last, input logic [15:0] data);
        srcq[inst][s][wp[inst][s] % 16] = {last, data};
        wp[inst][s]++;
    endtask

    task automatic drive();
        for (int s = 0; s < 2; s++) begin
            a_in[s].valid = en[0][s] && (rp[0][s] != wp[0][s]);
            {a_in[s].last, a_in[s].data} = srcq[0][s][rp[0][s] % 16];
            b_in[s].valid = en[1][s] && (rp[1][s] != wp[1][s]);
            {b_in[s].last, b_in[s].data} = srcq[1][s][rp[1][s] % 16];
        end
        for (int s = 0; s < 4; s++) begin
            c_in[s].valid = c_run;
            c_in[s].last  = c_phase[s];
            c_in[s].data  = {2'(s), c_phase[s], c_seq[s]};
        end
        c_ordy = c_run ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    // One clock cycle: drive, sample, account for handshakes, move to next cycle.
    task automatic step();
        logic [16:0] c_exp;
        drive();
        #1;
        sa_out  = a_out;  sa_rdy = a_rdy;  sa_lock = a_lock;  sa_gid = a_gid;
        sb_out  = b_out;  sb_rdy = b_rdy;  sb_lock = b_lock;  sb_gid = b_gid;
        sa_vld  = {a_in[1].valid, a_in[0].valid};
        sb_vld  = {b_in[1].valid, b_in[0].valid};
        for (int s = 0; s < 2; s++) begin
            if (a_in[s].valid && a_rdy[s]) rp[0][s]++;
            if (b_in[s].valid && b_rdy[s]) rp[1][s]++;
        end
        for (int s = 0; s < 4; s++) begin
            if (c_in[s].valid && c_rdy[s]) begin
                if (c_phase[s]) c_seq[s]++;
                c_phase[s] = ~c_phase[s];
            end
        end
        if (c_out.valid && c_ordy) begin
            // All four streams always request, so packets leave in strict
            // rotation 0,1,2,3,... and never interleave.
            c_exp = {exp_ph, 2'(exp_k % 4), exp_ph, 13'(exp_k / 4)};
            check("c_flit", {c_out.last, c_out.data}, c_exp);
            if (c_out.last) c_cnt[c_out.data[15:14]]++;
            if (exp_ph) exp_k++;
            exp_ph = ~exp_ph;
        end
        @(negedge clk);
    endtask

    task automatic chk_a(input string tag, input logic v, input logic l, input logic [15:0] d,
                         input logic [1:0] hs, input logic lk, input logic gid);
        check({tag, "_valid"}, sa_out.valid, v);
        if (v) check({tag, "_flit"}, {sa_out.last, sa_out.data}, {l, d});
        check({tag, "_hs"}, sa_rdy & sa_vld, hs);
        check({tag, "_lock"}, sa_lock, lk);
        check({tag, "_gid"}, sa_gid, gid);
    endtask

    task automatic chk_b(input string tag, input logic v, input logic l, input logic [15:0] d,
                         input logic [1:0] hs, input logic lk, input logic gid);
        check({tag, "_valid"}, sb_out.valid, v);
        if (v) check({tag, "_flit"}, {sb_out.last, sb_out.data}, {l, d});
        check({tag, "_hs"}, sb_rdy & sb_vld, hs);
        check({tag, "_lock"}, sb_lock, lk);
        check({tag, "_gid"}, sb_gid, gid);
    endtask

    initial begin
        int cmin, cmax, ctot;
        rst    = 1'b1;
        a_ordy = 1'b1;
        b_ordy = 1'b1;
        c_run  = 1'b0;
        exp_k  = 0;
        exp_ph = 1'b0;
        for (int s = 0; s < 4; s++) begin
            c_phase[s] = 1'b0;
            c_seq[s]   = '0;
            c_cnt[s]   = 0;
        end
        clear_src(0);
        clear_src(1);
        @(negedge clk);

        // ---- Reset: sources of u_a already valid, nothing may be taken ----
        for (int k = 0; k < 3; k++) begin
            push_flit(0, 0, 1'b1, 16'hA000);
            push_flit(0, 1, 1'b1, 16'hB000);
        end
        step();
        step();
        check("rst_a_valid", sa_out.valid, 1'b0);
        check("rst_a_ready", sa_rdy, 2'b00);
        check("rst_a_lock",  sa_lock, 1'b0);
        check("rst_a_gid",   sa_gid, 1'b0);
        check("rst_b_valid", sb_out.valid, 1'b0);
        check("rst_b_ready", sb_rdy, 2'b00);
        check("rst_b_lock",  sb_lock, 1'b0);
        rst = 1'b0;

        // ---- 1: single-flit packets alternate, stream 0 first ----
        for (int k = 0; k < 6; k++) begin
            step();
            chk_a("t1", 1'b1, 1'b1, (k % 2) ? 16'hB000 : 16'hA000,
                  (k % 2) ? 2'b10 : 2'b01, 1'b0, 1'(k % 2));
        end

        // ---- 2: 3-flit packet from stream 0 holds off stream 1 ----
        clear_src(0);
        push_flit(0, 0, 1'b0, 16'h0001);
        push_flit(0, 0, 1'b0, 16'h0002);
        push_flit(0, 0, 1'b1, 16'h0003);
        push_flit(0, 1, 1'b1, 16'h000F);
        en[0][1] = 1'b0;
        step(); chk_a("t2_c0", 1'b1, 1'b0, 16'h0001, 2'b01, 1'b0, 1'b0);
        en[0][1] = 1'b1;
        step(); chk_a("t2_c1", 1'b1, 1'b0, 16'h0002, 2'b01, 1'b1, 1'b0);
        step(); chk_a("t2_c2", 1'b1, 1'b1, 16'h0003, 2'b01, 1'b1, 1'b0);
        step(); chk_a("t2_c3", 1'b1, 1'b1, 16'h000F, 2'b10, 1'b0, 1'b1);

        // ---- 3: owner bubbles mid-packet, waiting stream is not granted ----
        clear_src(0);
        push_flit(0, 1, 1'b0, 16'h0011);
        push_flit(0, 1, 1'b0, 16'h0012);
        push_flit(0, 1, 1'b1, 16'h0013);
        push_flit(0, 0, 1'b1, 16'h0005);
        en[0][0] = 1'b0;
        step(); chk_a("t3_c0", 1'b1, 1'b0, 16'h0011, 2'b10, 1'b0, 1'b1);
        en[0][0] = 1'b1;
        en[0][1] = 1'b0;
        step(); chk_a("t3_c1", 1'b0, 1'b0, 16'h0000, 2'b00, 1'b1, 1'b1);
        step(); chk_a("t3_c2", 1'b0, 1'b0, 16'h0000, 2'b00, 1'b1, 1'b1);
        en[0][1] = 1'b1;
        step(); chk_a("t3_c3", 1'b1, 1'b0, 16'h0012, 2'b10, 1'b1, 1'b1);
        step(); chk_a("t3_c4", 1'b1, 1'b1, 16'h0013, 2'b10, 1'b1, 1'b1);
        step(); chk_a("t3_c5", 1'b1, 1'b1, 16'h0005, 2'b01, 1'b0, 1'b0);

        // ---- 4: skid fills to 2 under stall, then drains 1 per cycle ----
        clear_src(1);
        push_flit(1, 0, 1'b0, 16'h0021);
        push_flit(1, 0, 1'b0, 16'h0022);
        push_flit(1, 0, 1'b0, 16'h0023);
        push_flit(1, 0, 1'b1, 16'h0024);
        b_ordy = 1'b0;
        step(); chk_b("t4_c0", 1'b0, 1'b0, 16'h0000, 2'b01, 1'b0, 1'b0);
        step(); chk_b("t4_c1", 1'b1, 1'b0, 16'h0021, 2'b01, 1'b1, 1'b0);
        step(); chk_b("t4_c2", 1'b1, 1'b0, 16'h0021, 2'b00, 1'b1, 1'b0);
        step(); chk_b("t4_c3", 1'b1, 1'b0, 16'h0021, 2'b00, 1'b1, 1'b0);
        step(); chk_b("t4_c4", 1'b1, 1'b0, 16'h0021, 2'b00, 1'b1, 1'b0);
        check("t4_buffered", rp[1][0], 2);
        b_ordy = 1'b1;
        step(); chk_b("t4_c5", 1'b1, 1'b0, 16'h0021, 2'b00, 1'b1, 1'b0);
        step(); chk_b("t4_c6", 1'b1, 1'b0, 16'h0022, 2'b01, 1'b1, 1'b0);
        step(); chk_b("t4_c7", 1'b1, 1'b0, 16'h0023, 2'b01, 1'b1, 1'b0);
        step(); chk_b("t4_c8", 1'b1, 1'b1, 16'h0024, 2'b00, 1'b0, 1'b0);
        step(); chk_b("t4_c9", 1'b0, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b0);

        // ---- 5: reset mid-packet with one flit in the skid ----
        clear_src(1);
        push_flit(1, 1, 1'b0, 16'h0031);
        push_flit(1, 1, 1'b0, 16'h0032);
        push_flit(1, 1, 1'b0, 16'h0033);
        push_flit(1, 1, 1'b1, 16'h0034);
        b_ordy = 1'b0;
        step(); chk_b("t5_c0", 1'b0, 1'b0, 16'h0000, 2'b10, 1'b0, 1'b1);
        rst = 1'b1;
        step();
        check("t5_rst_valid", sb_out.valid, 1'b0);
        check("t5_rst_ready", sb_rdy, 2'b00);
        check("t5_rst_taken", rp[1][1], 1);
        rst = 1'b0;
        clear_src(1);
        push_flit(1, 0, 1'b1, 16'h0041);
        push_flit(1, 1, 1'b1, 16'h0042);
        b_ordy = 1'b1;
        step(); chk_b("t5_c2", 1'b0, 1'b0, 16'h0000, 2'b01, 1'b0, 1'b0);
        step(); chk_b("t5_c3", 1'b1, 1'b1, 16'h0041, 2'b10, 1'b0, 1'b1);
        step(); chk_b("t5_c4", 1'b1, 1'b1, 16'h0042, 2'b00, 1'b0, 1'b1);

        // ---- 6: N=4, 2-flit packets, random out_ready ----
        c_run = 1'b1;
        for (int k = 0; k < 1000; k++) step();
        c_run = 1'b0;
        step();
        step();
        cmin = c_cnt[0];
        cmax = c_cnt[0];
        ctot = 0;
        for (int s = 0; s < 4; s++) begin
            if (c_cnt[s] < cmin) cmin = c_cnt[s];
            if (c_cnt[s] > cmax) cmax = c_cnt[s];
            ctot += c_cnt[s];
        end
        check("t6_fair", 32'(cmax - cmin <= 1), 32'd1);
        check("t6_progress", 32'(ctot >= 100), 32'd1);
        check("t6_total", ctot, exp_k);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
